pc_seq_ctrl: RTL and testbench
==============================

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0001_0000: PC value driven on pc_next during reset.
REQ-002 Parameter MAX_WAIT, default 8: maximum LOAD_WAIT cycles before timeout, legal range 2..255.
REQ-003 Parameter TRAP_VEC, default 32'h0000_0100: redirect target on misaligned-target trap.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 pc_cur  in  32  current PC register value.
REQ-007 is_load  in  1  decoder flag: current instruction is a load.
REQ-008 mem_ready  in  1  data memory completed the pending load.
REQ-009 jump  in  1  unconditional jump in the current instruction.
REQ-010 jump_target  in  32  jump destination.
REQ-011 branch_taken  in  1  resolved taken branch.
REQ-012 branch_target  in  32  branch destination.
REQ-013 pc_next  out  32  value for the PC register to load.
REQ-014 pc_we  out  1  PC register write enable.
REQ-015 stall  out  1  hold the fetch/decode stages.
REQ-016 flush  out  1  registered; kill the instruction currently in decode.
REQ-017 mem_err  out  1  registered one-cycle pulse on load timeout.
REQ-018 trap  out  1  registered one-cycle pulse on misaligned redirect.

Function
REQ-019 The FSM SHALL have three states, RUN, LOAD_WAIT and REDIRECT; pc_next, pc_we and stall are combinational from state and inputs, and flush, mem_err and trap are registered.
REQ-020 In RUN, inputs SHALL be evaluated with priority jump > branch_taken > is_load > sequential.
REQ-021 RUN with jump: pc_next=jump_target, pc_we=1, stall=0; next state REDIRECT.
REQ-022 RUN with branch_taken and no jump: pc_next=branch_target, pc_we=1; next state REDIRECT.
REQ-023 RUN with is_load and no redirect: pc_we=0, stall=1, wait counter cleared to 0; next state LOAD_WAIT.
REQ-024 RUN with no event: pc_next=pc_cur+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), pc_we=1, stall=0.
REQ-025 In LOAD_WAIT with mem_ready=1: pc_next=pc_cur+4, pc_we=1, stall=0; next state RUN.
REQ-026 In LOAD_WAIT with mem_ready=0: pc_we=0, stall=1, and the counter increments.
REQ-027 When the counter reaches MAX_WAIT-1 with mem_ready=0: pc_we=1, pc_next=pc_cur+4, stall=0, mem_err pulses on the next cycle; next state RUN.
REQ-028 In LOAD_WAIT, jump, branch_taken and is_load SHALL be ignored.
REQ-029 In REDIRECT, flush SHALL be 1 for exactly this cycle; pc_next=pc_cur+4, pc_we=1, stall=0; next state RUN.
REQ-030 In REDIRECT, jump, branch_taken and is_load SHALL be ignored because the instruction is squashed.
REQ-031 A load PC is held for one or more cycles and then advanced by exactly 4.
REQ-032 pc_we SHALL never be 1 while stall=1.

Reset
REQ-033 While rst=1: pc_next=RESET_PC, pc_we=0, stall=0.
REQ-034 At the first clock edge with rst=1: state=RUN, counter=0, flush=0, mem_err=0, trap=0.
REQ-035 rst asserted in any state, including mid-LOAD_WAIT, SHALL abandon the operation; the FSM is in RUN on the first cycle after rst falls.

Configuration
REQ-036 Macro PC_SEQ_TRAP_EN SHALL control misaligned-target trapping.
REQ-037 With PC_SEQ_TRAP_EN defined, a RUN redirect whose selected target[1:0]!=2'b00 SHALL produce pc_next=TRAP_VEC and pc_we=1, with trap pulsing the next cycle; next state REDIRECT.
REQ-038 Without PC_SEQ_TRAP_EN, targets SHALL be used unmodified and trap is tied to 0.

Verification
REQ-039 Reset, then 3 idle cycles from pc_cur=32'h0001_0000: pc_next sequence 0x10004, 0x10008, 0x1000C, with pc_we=1 each cycle.
REQ-040 is_load in RUN, mem_ready rising 2 cycles later: stall=1 and pc_we=0 for 2 cycles, then pc_we=1 with pc_next=pc_cur+4 and state RUN.
REQ-041 is_load with mem_ready held 0, MAX_WAIT=8: stall for 8 cycles, then forced advance and a single mem_err pulse.
REQ-042 jump=1, branch_taken=1, is_load=1 in the same cycle with jump_target=0x2000: pc_next=0x2000, then one flush cycle, with branch and load ignored.
REQ-043 With PC_SEQ_TRAP_EN, branch_target=0x2002: pc_next=TRAP_VEC and a trap pulse; without the macro, pc_next=0x2002 and trap=0.
REQ-044 rst asserted during LOAD_WAIT, and pc_cur=0xFFFF_FFFC in RUN: the FSM returns to RUN with counter 0, and the wrap case gives pc_next=0.

Source files
------------

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: next-PC selection and fetch stall control.
// RUN advances sequentially or redirects (jump > branch), LOAD_WAIT holds the
// PC until memory answers or a bounded wait expires, REDIRECT squashes the
// instruction in decode. Define PC_SEQ_TRAP_EN to trap misaligned redirect
// targets to TRAP_VEC; left undefined, targets are used as given.
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0001_0000,
    parameter int          MAX_WAIT = 8,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    input  logic        is_load,
    input  logic        mem_ready,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc_next,
    output logic        pc_we,
    output logic        stall,
    output logic        flush,
    output logic        mem_err,
    output logic        trap
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOAD_WAIT = 2'd1,
        REDIRECT  = 2'd2
    } state_t;

    // Count value on which a load that is still pending gets forced forward.
    localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic        mem_err_q, mem_err_d;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;
`ifdef PC_SEQ_TRAP_EN
    logic        trap_q, trap_d;
`endif

    // Modulo-2^32 sequential address: 32'hFFFF_FFFC wraps to 0.
    assign pc_plus4 = pc_cur + 32'd4;

    // Next-state, wait counter, registered-pulse inputs and the combinational PC controls.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_d      = 1'b0;
        mem_err_d    = 1'b0;
`ifdef PC_SEQ_TRAP_EN
        trap_d       = 1'b0;
`endif
        redirect_tgt = jump ? jump_target : branch_target;
        pc_next      = pc_plus4;
        pc_we        = 1'b0;
        stall        = 1'b0;

        unique case (state_q)
            RUN: begin
                if (jump || branch_taken) begin
                    pc_we   = 1'b1;
                    flush_d = 1'b1;
                    state_d = REDIRECT;
`ifdef PC_SEQ_TRAP_EN
                    if (redirect_tgt[1:0] != 2'b00) begin
                        pc_next = TRAP_VEC;
                        trap_d  = 1'b1;
                    end else begin
                        pc_next = redirect_tgt;
                    end
`else
                    pc_next = redirect_tgt;
`endif
                end else if (is_load) begin
                    stall   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = LOAD_WAIT;
                end else begin
                    pc_we = 1'b1;
                end
            end
            LOAD_WAIT: begin
                // jump/branch/is_load belong to the stalled instruction and are ignored here.
                if (mem_ready) begin
                    pc_we   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = RUN;
                end else if (cnt_q == CNT_LAST) begin
                    pc_we     = 1'b1;
                    mem_err_d = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = RUN;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            REDIRECT: begin
                // The decode-stage instruction is squashed, so its flags are ignored.
                pc_we   = 1'b1;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (rst) begin
            pc_next = RESET_PC;
            pc_we   = 1'b0;
            stall   = 1'b0;
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values computed above.
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= 8'd0;
            flush_q   <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flush_q   <= flush_d;
            mem_err_q <= mem_err_d;
        end
    end

`ifdef PC_SEQ_TRAP_EN
    // Trap pulse register, present only when misaligned trapping is built in.
    always_ff @(posedge clk) begin
        if (rst) trap_q <= 1'b0;
        else     trap_q <= trap_d;
    end
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    assign flush   = flush_q;
    assign mem_err = mem_err_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed self-checking bench for pc_seq_ctrl (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
module tb_pc_seq_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0001_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic        is_load, mem_ready, jump, branch_taken;
    logic [31:0] jump_target, branch_target;
    logic [31:0] pc_next;
    logic        pc_we, stall, flush, mem_err, trap;

    int n_checks = 0;
    int n_pass   = 0;

    pc_seq_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .pc_cur        (pc_cur),
        .is_load       (is_load),
        .mem_ready     (mem_ready),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_next       (pc_next),
        .pc_we         (pc_we),
        .stall         (stall),
        .flush         (flush),
        .mem_err       (mem_err),
        .trap          (trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one clock, leaving time just after the edge for new stimulus.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic expect_run_advance(input string tag, input logic [31:0] pc);
        check({tag, "_pc_next"}, pc_next, pc + 32'd4);
        check({tag, "_pc_we"}, {31'd0, pc_we}, 32'd1);
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    endtask

    task automatic expect_stalled(input string tag);
        check({tag, "_stall"}, {31'd0, stall}, 32'd1);
        check({tag, "_pc_we"}, {31'd0, pc_we}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; pc_cur = 32'd0;
        is_load = 1'b0; mem_ready = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        jump_target = 32'd0; branch_target = 32'd0;

        // Reset behaviour.
        tick(); tick(); settle();
        check("rst_pc_next", pc_next, RESET_PC);
        check("rst_pc_we", {31'd0, pc_we}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_mem_err", {31'd0, mem_err}, 32'd0);
        check("rst_trap", {31'd0, trap}, 32'd0);

        // Three idle cycles from 0x10000.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_cur = 32'h0001_0000 + 32'(i * 4);
            settle();
            check($sformatf("idle%0d_pc_next", i), pc_next, 32'h0001_0004 + 32'(i * 4));
            check($sformatf("idle%0d_pc_we", i), {31'd0, pc_we}, 32'd1);
            tick();
        end

        // Load answered two cycles later; is_load left high in LOAD_WAIT is ignored.
        pc_cur = 32'h0001_0010; is_load = 1'b1; settle();
        expect_stalled("ld_run");
        tick(); settle();
        expect_stalled("ld_wait0");
        tick(); mem_ready = 1'b1; settle();
        expect_run_advance("ld_ready", 32'h0001_0010);
        tick(); mem_ready = 1'b0; is_load = 1'b0; pc_cur = 32'h0001_0014; settle();
        expect_run_advance("ld_back_run", 32'h0001_0014);
        check("ld_no_mem_err", {31'd0, mem_err}, 32'd0);
        tick();

        // Load timeout: 8 stall cycles, then forced advance; jump/branch ignored while waiting.
        pc_cur = 32'h0001_0018; is_load = 1'b1; settle();
        expect_stalled("to_run");
        tick();
        is_load = 1'b0; jump = 1'b1; branch_taken = 1'b1;
        jump_target = 32'h0000_4000; branch_target = 32'h0000_5000;
        for (int i = 0; i < 7; i++) begin
            settle();
            expect_stalled($sformatf("to_wait%0d", i));
            check($sformatf("to_wait%0d_mem_err", i), {31'd0, mem_err}, 32'd0);
            tick();
        end
        settle();
        expect_run_advance("to_forced", 32'h0001_0018);
        check("to_forced_flush", {31'd0, flush}, 32'd0);
        tick(); jump = 1'b0; branch_taken = 1'b0; pc_cur = 32'h0001_001C; settle();
        check("to_mem_err_pulse", {31'd0, mem_err}, 32'd1);
        check("to_no_flush", {31'd0, flush}, 32'd0);
        expect_run_advance("to_after", 32'h0001_001C);
        tick(); settle();
        check("to_mem_err_single", {31'd0, mem_err}, 32'd0);

        // Priority: jump beats branch and load; REDIRECT ignores all three.
        jump = 1'b1; branch_taken = 1'b1; is_load = 1'b1;
        jump_target = 32'h0000_2000; branch_target = 32'h0000_3000; settle();
        check("pri_pc_next", pc_next, 32'h0000_2000);
        check("pri_pc_we", {31'd0, pc_we}, 32'd1);
        check("pri_stall", {31'd0, stall}, 32'd0);
        tick(); pc_cur = 32'h0000_2000; settle();
        check("redir_flush", {31'd0, flush}, 32'd1);
        expect_run_advance("redir", 32'h0000_2000);
        tick(); jump = 1'b0; branch_taken = 1'b0; is_load = 1'b0; pc_cur = 32'h0000_2004; settle();
        check("redir_flush_once", {31'd0, flush}, 32'd0);
        expect_run_advance("redir_back_run", 32'h0000_2004);
        tick();

        // Misaligned branch target.
        branch_taken = 1'b1; branch_target = 32'h0000_2002; settle();
`ifdef PC_SEQ_TRAP_EN
        check("mis_pc_next", pc_next, TRAP_VEC);
`else
        check("mis_pc_next", pc_next, 32'h0000_2002);
`endif
        check("mis_pc_we", {31'd0, pc_we}, 32'd1);
        tick(); branch_taken = 1'b0; settle();
`ifdef PC_SEQ_TRAP_EN
        check("mis_trap", {31'd0, trap}, 32'd1);
`else
        check("mis_trap", {31'd0, trap}, 32'd0);
`endif
        check("mis_flush", {31'd0, flush}, 32'd1);
        tick(); settle();
        check("mis_trap_clear", {31'd0, trap}, 32'd0);

        // Reset during LOAD_WAIT, then PC wrap in RUN.
        pc_cur = 32'h0000_3000; is_load = 1'b1; settle();
        tick(); is_load = 1'b0; settle();
        expect_stalled("rl_wait");
        rst = 1'b1; settle();
        check("rl_rst_pc_next", pc_next, RESET_PC);
        check("rl_rst_pc_we", {31'd0, pc_we}, 32'd0);
        check("rl_rst_stall", {31'd0, stall}, 32'd0);
        tick(); rst = 1'b0; pc_cur = 32'hFFFF_FFFC; settle();
        check("wrap_pc_next", pc_next, 32'h0000_0000);
        check("wrap_pc_we", {31'd0, pc_we}, 32'd1);
        check("wrap_stall", {31'd0, stall}, 32'd0);
        check("wrap_mem_err", {31'd0, mem_err}, 32'd0);
        tick();

        // Counter restarted at 0: a fresh load must stall a full 8 cycles again.
        pc_cur = 32'h0000_0000; is_load = 1'b1; settle();
        expect_stalled("rc_run");
        tick(); is_load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            settle();
            expect_stalled($sformatf("rc_wait%0d", i));
            tick();
        end
        settle();
        expect_run_advance("rc_forced", 32'h0000_0000);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
